pe_ctx_seq: RTL
===============

Name: pe_ctx_seq

Overview:
Per-PE context sequencer. It drives the control words that the PE register file consumes.
- Holds a small context memory of per-cycle control words, loaded over a 32-bit config port.
- On `start`, replays the words for a programmed number of iterations.
- Presents one registered control word per cycle, aligned so the register file's negedge writes always see stable controls.
- Sits between the array configuration loader and the PE register-file/FU pair.

Parameters:
- CTX_DEPTH, 16, number of context words.
- CTX_AW, 4, context address width (log2 CTX_DEPTH).
- ITER_W, 8, width of the iteration counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  CTX_AW  context word index.
- cfg_hi  in  1  0 = write bits [31:0], 1 = write bits [63:32].
- cfg_data  in  32  config write data.
- cfg_err  out  1  one-cycle pulse: config write rejected because busy.
- ctx_len  in  CTX_AW  index of last word per iteration; sampled at start.
- iter_count  in  ITER_W  extra iterations (total = iter_count+1); sampled at start.
- start  in  1  begin run; level, sampled in IDLE only.
- stall  in  1  withhold issue this cycle.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- control_in  out  9  edge/bus select for register write.
- control_out  out  9  output edge enables.
- control_put_in, control_put_out, control_send, control_reg_1, control_reg_2  out  6 each  register indices.
- control_pe2fu_1, control_pe2fu_2  out  4 each  FU operand source selects.
- write_back, ld, ld_write  out  1 each  write enables.

Behaviour:
- Context word layout (64 bits):
  - [8:0] control_in, [17:9] control_out, [23:18] put_in, [29:24] put_out, [35:30] send.
  - [41:36] reg_1, [47:42] reg_2, [51:48] pe2fu_1, [55:52] pe2fu_2.
  - [56] write_back, [57] ld, [58] ld_write, [63:59] reserved, ignored.
- NOP word:
  - all control fields 0, except ld=1, ld_write=0, write_back=0.
  - ld=0 would write 0 into reg[put_in] every negedge, so NOP must keep ld=1.
  - Reset values: all control outputs = NOP; busy=0, done=0, cfg_err=0; state=IDLE; pc=0; iter=0. Context memory is not reset.
- All control outputs are registered. They change only on posedge and are stable across the following negedge.
- IDLE:
  - cfg_we writes the selected half of mem[cfg_addr] at posedge.
  - start=1 → pc<=0, len<=ctx_len, iter<=iter_count, state<=RUN. Outputs stay NOP.
- RUN, each posedge:
  - stall=1 → outputs<=NOP; pc and iter held.
  - stall=0 → outputs<=mem[pc], then:
    - pc!=len → pc<=pc+1.
    - pc==len and iter!=0 → pc<=0, iter<=iter-1.
    - pc==len and iter==0 → state<=DONE.
- DONE: outputs<=NOP, done<=1 for exactly one cycle, state<=IDLE.
- Latency and totals:
  - start sampled at posedge T; word0 is presented after posedge T+1.
  - Total issued words = (len+1)*(iter_count+1).
  - done is high in the cycle after the last word is presented.
- Boundaries:
  - ctx_len=0 → a single word per iteration.
  - iter_count=0 → a single pass.
  - ctx_len and iter_count changes during RUN are ignored.
- Config write while busy: the write is dropped and cfg_err pulses one cycle.
- start while busy is ignored.
- start held high through DONE→IDLE relaunches at the next posedge in IDLE.
- stall during DONE is ignored.
- RST_N low at any time: state, outputs and counters return immediately to reset values, including mid-RUN.
- No hazard checking between put_in and put_out indices; that is the compiler's responsibility.

Decomposition:
- Shared package `pe_ctx_pkg`:
  - field bit-position constants.
  - CTX_W=64.
  - NOP word constant.
  - state encoding IDLE/RUN/DONE.
- One natural sub-module: `pe_ctx_mem`, the CTX_DEPTH x 64 context store with half-word write enables and an asynchronous read port.

Test Plan:
- Reset: hold RST_N=0 → every control output equals NOP (ld=1, others 0); busy=0, done=0.
- Sequence and loop: load mem[0..2] with distinct words, ctx_len=2, iter_count=1, start pulse → words 0,1,2,0,1,2 on six consecutive cycles starting 2 posedges after start, then NOP with done=1 for 1 cycle, then busy=0.
- Stall: same program with stall=1 for the 2 cycles after word1 is issued → two NOP cycles, then word2; no word skipped or duplicated; 6 words total.
- Busy config guard: cfg_we to addr 0 during RUN → cfg_err=1 for 1 cycle; a read-back run after done still issues the original mem[0].
- Reset mid-run: RST_N low while word1 is presented → outputs NOP immediately; after release, the next start restarts at word0.
- Minimal program: ctx_len=0, iter_count=0 → exactly one word, then done pulse the next cycle.

Source files
------------

// File: rtl/pe_ctx_pkg.sv
// Shared definitions for the per-PE context sequencer: context word layout,
// the NOP control word and the sequencer state encoding.
package pe_ctx_pkg;

    localparam int unsigned CTX_W = 64;
    // Bits [63:59] are reserved; only the low CTL_W bits ever reach the PE.
    localparam int unsigned CTL_W = 59;

    localparam int unsigned CTL_IN_LSB  = 0;
    localparam int unsigned CTL_OUT_LSB = 9;
    localparam int unsigned PUT_IN_LSB  = 18;
    localparam int unsigned PUT_OUT_LSB = 24;
    localparam int unsigned SEND_LSB    = 30;
    localparam int unsigned REG1_LSB    = 36;
    localparam int unsigned REG2_LSB    = 42;
    localparam int unsigned PE2FU1_LSB  = 48;
    localparam int unsigned PE2FU2_LSB  = 52;
    localparam int unsigned WB_BIT      = 56;
    localparam int unsigned LD_BIT      = 57;
    localparam int unsigned LDW_BIT     = 58;

    localparam int unsigned EDGE_W = 9;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned SEL_W  = 4;

    // ld stays high so the register file never latches zero into reg[put_in].
    localparam logic [CTX_W-1:0] CTX_NOP = 64'h0200_0000_0000_0000;

    typedef enum logic [1:0] {StIdle, StRun, StDone} ctx_state_e;

endpackage

// File: rtl/pe_ctx_seq_if.sv
// Config write port plus the control word bundle presented to the PE
// register file / FU pair.
interface pe_ctx_seq_if #(
    parameter int unsigned CTX_AW = 4
);
    logic              cfg_we;
    logic [CTX_AW-1:0] cfg_addr;
    logic              cfg_hi;
    logic [31:0]       cfg_data;
    logic              cfg_err;

    logic [8:0] control_in;
    logic [8:0] control_out;
    logic [5:0] control_put_in;
    logic [5:0] control_put_out;
    logic [5:0] control_send;
    logic [5:0] control_reg_1;
    logic [5:0] control_reg_2;
    logic [3:0] control_pe2fu_1;
    logic [3:0] control_pe2fu_2;
    logic       write_back;
    logic       ld;
    logic       ld_write;

    modport master (
        output cfg_we, cfg_addr, cfg_hi, cfg_data,
        input  cfg_err,
        input  control_in, control_out, control_put_in, control_put_out, control_send,
        input  control_reg_1, control_reg_2, control_pe2fu_1, control_pe2fu_2,
        input  write_back, ld, ld_write
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_hi, cfg_data,
        output cfg_err,
        output control_in, control_out, control_put_in, control_put_out, control_send,
        output control_reg_1, control_reg_2, control_pe2fu_1, control_pe2fu_2,
        output write_back, ld, ld_write
    );

endinterface

// File: rtl/pe_ctx_mem.sv
// Context word store: 32-bit half-word writes, asynchronous read.
// Deliberately not reset; contents are owned by the configuration loader.
module pe_ctx_mem
    import pe_ctx_pkg::*;
#(
    parameter int unsigned CTX_DEPTH = 16,
    parameter int unsigned CTX_AW    = 4
) (
    input  logic              CLK,
    input  logic              we,
    input  logic              hi,
    input  logic [CTX_AW-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [CTX_AW-1:0] raddr,
    output logic [CTX_W-1:0]  rdata
);

    logic [CTX_W-1:0] mem [CTX_DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            if (hi) mem[waddr][63:32] <= wdata;
            else    mem[waddr][31:0]  <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_ctx_seq.sv
// Per-PE context sequencer: replays programmed control words for a number of
// iterations, presenting one registered word per cycle to the register file.
module pe_ctx_seq
    import pe_ctx_pkg::*;
#(
    parameter int unsigned CTX_DEPTH = 16,
    parameter int unsigned CTX_AW    = 4,
    parameter int unsigned ITER_W    = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [CTX_AW-1:0] ctx_len,
    input  logic [ITER_W-1:0] iter_count,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    pe_ctx_seq_if.slave       bus
);

    ctx_state_e        state_q;
    logic [CTX_AW-1:0] pc_q;
    logic [CTX_AW-1:0] len_q;
    logic [ITER_W-1:0] iter_q;
    logic [CTL_W-1:0]  ctrl_q;
    logic              done_q;
    logic              cfg_err_q;

    logic [CTX_W-1:0]  rd_word;
    logic              mem_we;
    logic              unused_rsvd;

    // Config writes are only honoured while idle so a running program stays intact.
    assign mem_we = bus.cfg_we && (state_q == StIdle);

    pe_ctx_mem #(
        .CTX_DEPTH (CTX_DEPTH),
        .CTX_AW    (CTX_AW)
    ) u_mem (
        .CLK   (CLK),
        .we    (mem_we),
        .hi    (bus.cfg_hi),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .raddr (pc_q),
        .rdata (rd_word)
    );

    assign unused_rsvd = ^rd_word[CTX_W-1:CTL_W];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            len_q     <= '0;
            iter_q    <= '0;
            ctrl_q    <= CTX_NOP[CTL_W-1:0];
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= bus.cfg_we && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    ctrl_q <= CTX_NOP[CTL_W-1:0];
                    if (start) begin
                        pc_q    <= '0;
                        len_q   <= ctx_len;
                        iter_q  <= iter_count;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (stall) begin
                        ctrl_q <= CTX_NOP[CTL_W-1:0];
                    end else begin
                        ctrl_q <= rd_word[CTL_W-1:0];
                        if (pc_q != len_q) begin
                            pc_q <= pc_q + CTX_AW'(1);
                        end else if (iter_q != '0) begin
                            pc_q   <= '0;
                            iter_q <= iter_q - ITER_W'(1);
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    ctrl_q  <= CTX_NOP[CTL_W-1:0];
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;

    assign bus.cfg_err         = cfg_err_q;
    assign bus.control_in      = ctrl_q[CTL_IN_LSB  +: EDGE_W];
    assign bus.control_out     = ctrl_q[CTL_OUT_LSB +: EDGE_W];
    assign bus.control_put_in  = ctrl_q[PUT_IN_LSB  +: IDX_W];
    assign bus.control_put_out = ctrl_q[PUT_OUT_LSB +: IDX_W];
    assign bus.control_send    = ctrl_q[SEND_LSB    +: IDX_W];
    assign bus.control_reg_1   = ctrl_q[REG1_LSB    +: IDX_W];
    assign bus.control_reg_2   = ctrl_q[REG2_LSB    +: IDX_W];
    assign bus.control_pe2fu_1 = ctrl_q[PE2FU1_LSB  +: SEL_W];
    assign bus.control_pe2fu_2 = ctrl_q[PE2FU2_LSB  +: SEL_W];
    assign bus.write_back      = ctrl_q[WB_BIT];
    assign bus.ld              = ctrl_q[LD_BIT];
    assign bus.ld_write        = ctrl_q[LDW_BIT];

endmodule
